// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and widths for the instruction-memory loader
// Purpose: loader FSM state enum plus byte/word widths used by every loader file.
// Ports: none (package).
package imem_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus
// Purpose: bundles the program byte stream handshake and the memory write port.
// Signals: in_valid/in_data/in_ready (byte stream), mem_we/mem_addr/mem_wdata (memory write).
// Modports: slave = the loader, master = the stream source / memory side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) ();

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_pair_assembler.sv
// rtl/imem_loader_byte_pair_assembler.sv - joins a high and a low byte into a 16-bit word
// Purpose: latches the high byte, exposes {hi, byte_i} combinationally for the header
//          decode, and registers {hi, lo} with a one-cycle strobe for memory writes.
// Ports: clock, reset_n, hi_load_i (latch byte_i as high byte), word_load_i (low byte
//        accepted, emit word next cycle), byte_i, pair_o (combinational {hi, byte_i}),
//        word_o (registered word), word_stb_o (one-cycle write strobe).
module byte_pair_assembler
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hi_load_i,
  input  logic              word_load_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] pair_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_stb_o
);

  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              stb_q, stb_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      word_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      word_q <= word_d;
      stb_q  <= stb_d;
    end
  end

  always_comb begin
    hi_d   = hi_q;
    word_d = word_q;
    stb_d  = word_load_i;
    if (hi_load_i)   hi_d   = byte_i;
    if (word_load_i) word_d = {hi_q, byte_i};
  end

  assign pair_o     = {hi_q, byte_i};
  assign word_o     = word_q;
  assign word_stb_o = stb_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into instruction memory
// Purpose: parses a 16-bit word count N (high byte first) followed by N 16-bit words
//          and writes them to sequential addresses from 0, then raises done; a count
//          larger than the memory depth raises error instead.
// Ports: clock, reset_n (async active-low), start (reload from DONE/ERR),
//        done, error (sticky status), bus (imem_loader_if slave: stream in, memory out).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  output logic         done,
  output logic         error,
  imem_loader_if.slave bus
);

  localparam logic [16:0] DEPTH_EXT = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       n_q, n_d;
  // Holds in_ready low while in reset and until the first clock after release.
  logic              alive_q;

  logic              accept;
  logic              hi_load;
  logic              word_load;
  logic [WORD_W-1:0] pair;
  logic [WORD_W-1:0] word;
  logic              word_stb;
  logic [16:0]       idx_inc_ext;

  byte_pair_assembler u_asm (
    .clock       (clock),
    .reset_n     (reset_n),
    .hi_load_i   (hi_load),
    .word_load_i (word_load),
    .byte_i      (bus.in_data),
    .pair_o      (pair),
    .word_o      (word),
    .word_stb_o  (word_stb)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HDR_HI;
      idx_q   <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      alive_q <= 1'b1;
    end
  end

  // Wide increment so the final word of a full-depth load compares against N correctly.
  assign idx_inc_ext = 17'(idx_q) + 17'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    n_d     = n_q;
    case (state_q)
      HDR_HI:  if (accept) state_d = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          n_d = pair;
          if ({1'b0, pair} > DEPTH_EXT) state_d = ERR;
          else if (pair == '0)          state_d = DONE;
          else                          state_d = DATA_HI;
        end
      end
      DATA_HI: if (accept) state_d = DATA_LO;
      DATA_LO: begin
        if (accept) begin
          addr_d = idx_q;
          idx_d  = idx_q + ADDR_W'(1);
          if (idx_inc_ext == {1'b0, n_q}) state_d = DONE;
          else                            state_d = DATA_HI;
        end
      end
      DONE, ERR: begin
        if (start) begin
          state_d = HDR_HI;
          idx_d   = '0;
        end
      end
      default: state_d = HDR_HI;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (state_q)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO: bus.in_ready = alive_q;
      DONE:                             done         = 1'b1;
      ERR:                              error        = 1'b1;
      default:                          bus.in_ready = 1'b0;
    endcase
    accept    = bus.in_ready & bus.in_valid;
    hi_load   = accept & ((state_q == HDR_HI) | (state_q == DATA_HI));
    word_load = accept & (state_q == DATA_LO);
  end

  assign bus.mem_we    = word_stb;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        done;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n;
  logic start_a, start_b;
  logic done_a, error_a, done_b, error_b;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t q_a[$];
  wr_t q_b[$];

  imem_loader_if #(.ADDR_W(10)) ifa ();
  imem_loader_if #(.ADDR_W(2))  ifb ();

  imem_loader #(.ADDR_W(10)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_a),
    .done    (done_a),
    .error   (error_a),
    .bus     (ifa.slave)
  );

  imem_loader #(.ADDR_W(2)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_b),
    .done    (done_b),
    .error   (error_b),
    .bus     (ifb.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] addr, input logic [31:0] data);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual write addr=%0h data=%0h required no write (t=%0t)", name, addr, data, $time);
  endtask

  // Scoreboard monitors: every mem_we cycle must match the next queued write.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && ifa.mem_we === 1'b1) begin
      wr_t e;
      if (q_a.size() == 0) unexpected("a_unexpected_write", 32'(ifa.mem_addr), 32'(ifa.mem_wdata));
      else begin
        e = q_a.pop_front();
        chk("a_wr_addr", 32'(ifa.mem_addr), 32'(e.addr));
        chk("a_wr_data", 32'(ifa.mem_wdata), 32'(e.data));
        chk("a_wr_done", 32'(done_a), 32'(e.done));
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1 && ifb.mem_we === 1'b1) begin
      wr_t e;
      if (q_b.size() == 0) unexpected("b_unexpected_write", 32'(ifb.mem_addr), 32'(ifb.mem_wdata));
      else begin
        e = q_b.pop_front();
        chk("b_wr_addr", 32'(ifb.mem_addr), 32'(e.addr));
        chk("b_wr_data", 32'(ifb.mem_wdata), 32'(e.data));
        chk("b_wr_done", 32'(done_b), 32'(e.done));
      end
    end
  end

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  // Called just after a rising edge; holds the byte until it is accepted.
  task automatic send(input bit sel, input logic [7:0] b);
    int  t;
    bit  ok;
    if (sel) begin ifb.in_valid = 1'b1; ifb.in_data = b; end
    else     begin ifa.in_valid = 1'b1; ifa.in_data = b; end
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 40) begin
      @(negedge clock);
      t++;
      if ((sel ? ifb.in_ready : ifa.in_ready) === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout actual in_ready=0 for 40 cycles required accept of byte %0h", b);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_seq(input bit sel, input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(sel, bytes[i]);
    if (sel) ifb.in_valid = 1'b0;
    else     ifa.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    align();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic push(input bit sel, input logic [15:0] addr, input logic [15:0] data, input logic dn);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.done = dn;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    start_a      = 1'b0;
    start_b      = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.in_data  = 8'h00;
    ifb.in_valid = 1'b0;
    ifb.in_data  = 8'h00;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_mem_we",   32'(ifa.mem_we),   32'd0);
    chk("rst_mem_addr", 32'(ifa.mem_addr), 32'd0);
    chk("rst_mem_wdata",32'(ifa.mem_wdata),32'd0);
    chk("rst_done",     32'(done_a),       32'd0);
    chk("rst_error",    32'(error_a),      32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready_before_clk", 32'(ifa.in_ready), 32'd0);
    @(negedge clock);
    chk("rel_in_ready_after_clk", 32'(ifa.in_ready), 32'd1);

    // Two words back-to-back, done rises with the second write
    align();
    push(0, 16'd0, 16'h701F, 1'b0);
    push(0, 16'd1, 16'h7207, 1'b1);
    send_seq(0, '{8'h00, 8'h02, 8'h70, 8'h1F, 8'h72, 8'h07});
    @(negedge clock);
    chk("two_words_we_latency", 32'(ifa.mem_we), 32'd1);
    chk("two_words_done",       32'(done_a),     32'd1);
    chk("two_words_in_ready",   32'(ifa.in_ready), 32'd0);

    // Reload after DONE, then an empty program
    pulse_start(0);
    @(negedge clock);
    chk("reload_done_clear", 32'(done_a), 32'd0);
    chk("reload_in_ready",   32'(ifa.in_ready), 32'd1);
    align();
    send_seq(0, '{8'h00, 8'h00});
    @(negedge clock);
    chk("empty_done",  32'(done_a),     32'd1);
    chk("empty_no_we", 32'(ifa.mem_we), 32'd0);

    // Gap of 5 cycles between high and low byte
    pulse_start(0);
    push(0, 16'd0, 16'h1234, 1'b1);
    send_seq(0, '{8'h00, 8'h01, 8'h12});
    repeat (5) @(negedge clock);
    chk("gap_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("gap_done",     32'(done_a),       32'd0);
    align();
    send_seq(0, '{8'h34});
    @(negedge clock);
    chk("gap_done_after", 32'(done_a), 32'd1);

    // start during DATA_HI is ignored
    pulse_start(0);
    send_seq(0, '{8'h00, 8'h02});
    pulse_start(0);
    @(negedge clock);
    chk("start_ignored_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("start_ignored_done",     32'(done_a),       32'd0);
    align();
    push(0, 16'd0, 16'hAABB, 1'b0);
    push(0, 16'd1, 16'hCCDD, 1'b1);
    send_seq(0, '{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    @(negedge clock);
    chk("start_ignored_final_done", 32'(done_a), 32'd1);

    // Reset mid-second-word, then reload
    pulse_start(0);
    push(0, 16'd0, 16'h1111, 1'b0);
    send_seq(0, '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22});
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("midrst_mem_we",   32'(ifa.mem_we),   32'd0);
    chk("midrst_mem_addr", 32'(ifa.mem_addr), 32'd0);
    chk("midrst_mem_wdata",32'(ifa.mem_wdata),32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    align();
    push(0, 16'd0, 16'hABCD, 1'b1);
    send_seq(0, '{8'h00, 8'h01, 8'hAB, 8'hCD});
    @(negedge clock);
    chk("midrst_reload_done",  32'(done_a),  32'd1);
    chk("midrst_reload_error", 32'(error_a), 32'd0);

    // ADDR_W=2: N=5 exceeds depth 4
    align();
    send_seq(1, '{8'h00, 8'h05});
    ifb.in_valid = 1'b1;
    ifb.in_data  = 8'h00;
    repeat (3) @(negedge clock);
    chk("err_error",    32'(error_b),      32'd1);
    chk("err_in_ready", 32'(ifb.in_ready), 32'd0);
    chk("err_done",     32'(done_b),       32'd0);
    ifb.in_valid = 1'b0;
    pulse_start(1);
    @(negedge clock);
    chk("err_start_error",    32'(error_b),      32'd0);
    chk("err_start_in_ready", 32'(ifb.in_ready), 32'd1);

    // ADDR_W=2: N=4 fills the whole memory and is legal
    align();
    push(1, 16'd0, 16'h1000, 1'b0);
    push(1, 16'd1, 16'h1001, 1'b0);
    push(1, 16'd2, 16'h1002, 1'b0);
    push(1, 16'd3, 16'h1003, 1'b1);
    send_seq(1, '{8'h00, 8'h04, 8'h10, 8'h00, 8'h10, 8'h01, 8'h10, 8'h02, 8'h10, 8'h03});
    @(negedge clock);
    chk("full_done",  32'(done_b),  32'd1);
    chk("full_error", 32'(error_b), 32'd0);

    repeat (3) @(negedge clock);
    chk("sb_a_drained", 32'(q_a.size()), 32'd0);
    chk("sb_b_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
